// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Types, widths and helpers shared by the game bookkeeping logic and by its
// consumers (HUD renderer and similar).
//   SCORE_W       width of the score registers and display bus
//   LIVES_W       width of the lives registers and display bus
//   game_state_t  game-phase encoding
//   alien_points  points awarded for destroying an alien of a given type
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int SCORE_W = 8;
    localparam int LIVES_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_HIT       = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

    function automatic logic [SCORE_W-1:0] alien_points(input logic [1:0] alien_type);
        logic [SCORE_W-1:0] pts;
        case (alien_type)
            2'd0:    pts = SCORE_W'(1);
            2'd1:    pts = SCORE_W'(2);
            2'd2:    pts = SCORE_W'(3);
            default: pts = SCORE_W'(5);
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/sat_add8.sv
// -----------------------------------------------------------------------------
// sat_add8
// Combinational three-operand saturating adder.
//   a, b, c  in   SCORE_W  operands
//   sum      out  SCORE_W  a+b+c, clamped to all-ones on overflow
//   ovf      out  1        true sum did not fit in SCORE_W bits
// -----------------------------------------------------------------------------
module sat_add8
    import game_pkg::*;
(
    input  logic [SCORE_W-1:0] a,
    input  logic [SCORE_W-1:0] b,
    input  logic [SCORE_W-1:0] c,
    output logic [SCORE_W-1:0] sum,
    output logic               ovf
);

    // Two guard bits: three full-scale operands can reach 3*255.
    logic [SCORE_W+1:0] wide;

    assign wide = {2'b00, a} + {2'b00, b} + {2'b00, c};
    assign ovf  = |wide[SCORE_W+1:SCORE_W];
    assign sum  = ovf ? '1 : wide[SCORE_W-1:0];

endmodule

// File: rtl/game_stats.sv
// -----------------------------------------------------------------------------
// game_stats
// Gameplay bookkeeping upstream of the HUD: score, lives, one extra life per
// game, post-hit invulnerability and the game-phase state machine. The HUD
// copies (score_disp/lives_disp) only move on frame_tick so a frame never
// shows a half-updated value.
//   clk, rst_n    clock, synchronous active-low reset
//   frame_tick    start-of-vblank pulse
//   start         start/restart pulse (honoured in IDLE and GAME_OVER)
//   alien_hit     alien destroyed, alien_type qualifies it
//   player_hit    player ship struck
//   wave_cleared  wave complete, adds WAVE_BONUS
//   score_disp    frame-stable score
//   lives_disp    frame-stable lives
//   playing       in PLAYING or HIT
//   invuln        in HIT
//   blink         in HIT, bit 2 of the invulnerability counter
//   game_over     in GAME_OVER
// -----------------------------------------------------------------------------
module game_stats
    import game_pkg::*;
#(
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int WAVE_BONUS    = 10,
    parameter int EXTRA_LIFE_AT = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               alien_hit,
    input  logic [1:0]         alien_type,
    input  logic               player_hit,
    input  logic               wave_cleared,
    output logic [SCORE_W-1:0] score_disp,
    output logic [LIVES_W-1:0] lives_disp,
    output logic               playing,
    output logic               invuln,
    output logic               blink,
    output logic               game_over
);

    localparam logic [LIVES_W-1:0] START_L   = LIVES_W'(START_LIVES);
    localparam logic [7:0]         INV_LOAD  = 8'(INVULN_FRAMES);
    localparam logic [SCORE_W-1:0] BONUS     = SCORE_W'(WAVE_BONUS);
    localparam logic [SCORE_W-1:0] XLIFE_TH  = SCORE_W'(EXTRA_LIFE_AT);
    localparam logic [LIVES_W-1:0] LIVES_MAX = '1;

    game_state_t        state, state_nxt;
    logic [SCORE_W-1:0] score, score_nxt;
    logic [LIVES_W-1:0] lives, lives_nxt;
    logic [7:0]         inv_cnt, inv_nxt;
    logic               xlife_given, xlife_nxt;

    logic [SCORE_W-1:0] add_pts, add_bonus, sum;
    logic               sum_ovf;
    logic               scoring, xlife_award;
    logic [LIVES_W-1:0] lives_x;

    assign add_pts   = alien_hit    ? alien_points(alien_type) : '0;
    assign add_bonus = wave_cleared ? BONUS : '0;

    sat_add8 u_add (
        .a   (score),
        .b   (add_pts),
        .c   (add_bonus),
        .sum (sum),
        .ovf (sum_ovf)
    );

    assign scoring     = (state == ST_PLAYING) || (state == ST_HIT);
    // A saturated sum means the score reached the ceiling, which is past any
    // representable threshold.
    assign xlife_award = scoring && !xlife_given && (sum_ovf || sum >= XLIFE_TH);
    // Extra life is applied before a coincident hit is evaluated.
    assign lives_x     = !xlife_award        ? lives :
                         (lives == LIVES_MAX) ? lives : lives + 2'd1;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        score_nxt = score;
        lives_nxt = lives;
        inv_nxt   = inv_cnt;
        xlife_nxt = xlife_given;
        // NOTE: blocking assignments here, combinational logic is evaluated
        // in order; the registers below use non-blocking instead.
        case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    score_nxt = '0;
                    lives_nxt = START_L;
                    inv_nxt   = '0;
                    xlife_nxt = 1'b0;
                    state_nxt = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                score_nxt = sum;
                lives_nxt = lives_x;
                if (xlife_award) xlife_nxt = 1'b1;
                if (player_hit) begin
                    if (lives_x == 2'd1) begin
                        lives_nxt = '0;
                        state_nxt = ST_GAME_OVER;
                    end else begin
                        lives_nxt = lives_x - 2'd1;
                        inv_nxt   = INV_LOAD;
                        state_nxt = ST_HIT;
                    end
                end
            end
            ST_HIT: begin
                score_nxt = sum;
                lives_nxt = lives_x;
                if (xlife_award) xlife_nxt = 1'b1;
                if (frame_tick) begin
                    inv_nxt = inv_cnt - 8'd1;
                    if (inv_cnt == 8'd1) state_nxt = ST_PLAYING;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            score       <= '0;
            lives       <= '0;
            inv_cnt     <= '0;
            xlife_given <= 1'b0;
            score_disp  <= '0;
            lives_disp  <= '0;
            playing     <= 1'b0;
            invuln      <= 1'b0;
            blink       <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_nxt;
            score       <= score_nxt;
            lives       <= lives_nxt;
            inv_cnt     <= inv_nxt;
            xlife_given <= xlife_nxt;
            // Snapshot takes the pre-update values: a coincident event shows
            // on the following tick.
            if (frame_tick) begin
                score_disp <= score;
                lives_disp <= lives;
            end
            playing   <= (state_nxt == ST_PLAYING) || (state_nxt == ST_HIT);
            invuln    <= (state_nxt == ST_HIT);
            blink     <= (state_nxt == ST_HIT) && inv_nxt[2];
            game_over <= (state_nxt == ST_GAME_OVER);
        end
    end

endmodule
